uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter that succeeds the fixed 8N1 `uart_tx`. It adds:
- configurable data width, parity and stop bits;
- an internal FIFO with a valid/ready write port, so producers such as the IMU sample packer can queue bytes without waiting on `tx_busy`;
- gap-free, back-to-back frames.

It sits between the packet formatter and the board TX pin.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_tx_fifo.sv | 138 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, FSM encoding and baud divisor helper
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // A divisor below 2 cannot hold a bit for a full baud period; 0 flags it.
  function automatic int baud_div(input int clk_hz, input int baud);
    int div;
    div = clk_hz / baud;
    return (div < 2) ? 0 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push;
  logic             pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with configurable data, parity and stop bits
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = PARITY_NONE,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [DATA_BITS-1:0]        in_data,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BW = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic       ODD       = (PARITY == PARITY_ODD);
  localparam bit CFG_OK = (BAUD_DIV >= 2) && (DATA_BITS >= 5) && (DATA_BITS <= 9)
                       && (PARITY == PARITY_NONE || PARITY == PARITY_EVEN || PARITY == PARITY_ODD)
                       && (STOP_BITS == 1 || STOP_BITS == 2)
                       && (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0);

  if (!CFG_OK) begin : g_bad_cfg
    $error("uart_tx_fifo: illegal parameter combination");
  end

  uart_state_e          state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 load;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .rd_en   (load),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != ST_IDLE) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;
    if (state_q != ST_IDLE) baud_d = (baud_q == '0) ? BAUD_LAST : baud_q - 1'b1;
    unique case (state_q)
      ST_IDLE: load = !fifo_empty;
      ST_START: if (baud_q == '0) begin
        state_d = ST_DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      ST_DATA: if (baud_q == '0) begin
        if (bit_q == DATA_LAST) begin
          bit_d   = '0;
          state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          tx_d    = (PARITY != PARITY_NONE) ? par_q : 1'b1;
        end else begin
          bit_d   = bit_q + 1'b1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_PARITY: if (baud_q == '0) begin
        state_d = ST_STOP;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
      ST_STOP: if (baud_q == '0) begin
        if (bit_q != STOP_LAST) begin
          bit_d = bit_q + 1'b1;
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Popping straight from the last stop cycle keeps frames back-to-back.
    if (load) begin
      state_d = ST_START;
      baud_d  = BAUD_LAST;
      shift_d = fifo_data;
      par_d   = (^fifo_data) ^ ODD;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - bench for uart_tx_fifo: 8N1, 7E2 and 7O2 instances against a frame-level model
module tb_uart_tx_fifo;

  localparam int CLK_HZ = 1_843_200;
  localparam int BD     = 16;
  localparam int DEPTH  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]      iv;
  logic [7:0]      din_a;
  logic [6:0]      din_p;
  logic [2:0]      tx_w, busy_w, ready_w;
  logic [2:0][2:0] cnt_w;

  uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(115_200), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut_8n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_data(din_a), .in_ready(ready_w[0]),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .fifo_count(cnt_w[0]));

  uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(115_200), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_7e2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_data(din_p), .in_ready(ready_w[1]),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .fifo_count(cnt_w[1]));

  uart_tx_fifo #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(115_200), .DATA_BITS(7), .PARITY(2),
                 .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut_7o2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_data(din_p), .in_ready(ready_w[2]),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .fifo_count(cnt_w[2]));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int peak0 = 0;
  int db [3] = '{8, 7, 7};
  int pm [3] = '{0, 1, 2};
  int sb [3] = '{1, 2, 2};

  // Model: queued words, and the frame currently on the line with the edge it began.
  int         mcnt   [3];
  int         mhead  [3];
  int         mstart [3];
  logic [8:0] mbuf   [3][DEPTH];
  logic [8:0] mword  [3];
  bit         mact   [3];

  function automatic int frame_len(input int d);
    return BD * (1 + db[d] + ((pm[d] != 0) ? 1 : 0) + sb[d]);
  endfunction

  function automatic logic frame_bit(input int d, input logic [8:0] w, input int idx);
    int ones;
    ones = 0;
    for (int i = 0; i < db[d]; i++) ones += int'(w[i]);
    if (idx == 0) return 1'b0;
    if (idx <= db[d]) return w[idx-1];
    if (pm[d] != 0 && idx == db[d] + 1) return (pm[d] == 1) ? ones[0] : ~ones[0];
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      mcnt[d] = 0; mhead[d] = 0; mact[d] = 1'b0; mstart[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int c0;
      logic [8:0] wd;
      wd = (d == 0) ? {1'b0, din_a} : {2'b00, din_p};
      if (!rst_n) begin
        mcnt[d] = 0; mhead[d] = 0; mact[d] = 1'b0;
      end else begin
        c0 = mcnt[d];
        if (mact[d] && cyc == mstart[d] + frame_len(d)) mact[d] = 1'b0;
        if (!mact[d] && mcnt[d] > 0) begin
          mword[d]  = mbuf[d][mhead[d]];
          mhead[d]  = (mhead[d] + 1) % DEPTH;
          mcnt[d]   = mcnt[d] - 1;
          mact[d]   = 1'b1;
          mstart[d] = cyc;
        end
        if (iv[d] && c0 != DEPTH) begin
          mbuf[d][(mhead[d] + mcnt[d]) % DEPTH] = wd;
          mcnt[d] = mcnt[d] + 1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      logic [5:0] obs;
      logic [5:0] exp;
      logic etx;
      etx = mact[d] ? frame_bit(d, mword[d], (cyc - mstart[d]) / BD) : 1'b1;
      exp = {etx, (mact[d] || mcnt[d] > 0), (mcnt[d] != DEPTH), 3'(mcnt[d])};
      obs = {tx_w[d], busy_w[d], ready_w[d], cnt_w[d]};
      tests++;
      assert (obs === exp) else begin
        fails++;
        $error("FAIL cycle_check dut%0d cyc=%0d observed={tx,busy,ready,cnt}=%b expected=%b", d, cyc, obs, exp);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    if (int'(cnt_w[0]) > peak0) peak0 = int'(cnt_w[0]);
    check_all();
  endtask

  task automatic wait_idle(input int d, output int t);
    int guard;
    guard = 0;
    while (busy_w[d] !== 1'b0 && guard < 3000) begin
      tick();
      guard++;
    end
    t = cyc;
  endtask

  initial begin
    int n, t1, bad;
    logic rdy;
    iv = '0; din_a = '0; din_p = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #1 chk("reset_state", {tx_w[0], busy_w[0], ready_w[0], cnt_w[0]}, 6'b101000);
    check_all();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single 8N1 frame: start one edge after the push, 160 cycles long.
    iv[0] = 1'b1; din_a = 8'h41; tick(); n = cyc; iv[0] = 1'b0;
    while (tx_w[0] && cyc < n + 20) tick();
    chk("t1_latency", cyc - n, 1);
    wait_idle(0, t1);
    chk("t1_frame_len", t1 - (n + 1), 160);

    peak0 = 0;
    iv[0] = 1'b1; din_a = 8'h41; tick(); n = cyc;
    din_a = 8'h5A; tick();
    din_a = 8'hFF; tick(); iv[0] = 1'b0;
    wait_idle(0, t1);
    chk("t2_span", t1 - (n + 1), 480);
    chk("t2_peak", peak0, 2);

    // Valid held over six words into a 4-deep FIFO.
    n = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      iv[0] = 1'b1; din_a = 8'(8'hA0 + i);
      do begin
        rdy = ready_w[0];
        tick();
      end while (!rdy && cyc < n + 400);
      if (i == 4) chk("t3_fifth_accept", cyc - n, 4);
      if (i == 5) chk("t3_sixth_accept", cyc - n, 162);
    end
    iv[0] = 1'b0;
    wait_idle(0, t1);
    chk("t3_span", t1 - (n + 1), 960);

    iv[1] = 1'b1; iv[2] = 1'b1; din_p = 7'h55; tick(); n = cyc; iv[1] = 1'b0; iv[2] = 1'b0;
    while (cyc < n + 1 + 8 * BD + 8) tick();
    chk("t4_even_parity", tx_w[1], 0);
    chk("t4_odd_parity", tx_w[2], 1);
    wait_idle(1, t1);
    chk("t4_frame_len", t1 - (n + 1), 176);
    chk("t4_odd_done", busy_w[2], 0);

    // Reset asserted in data bit 3 with two words still queued.
    iv[0] = 1'b1; din_a = 8'h3C; tick(); n = cyc;
    din_a = 8'hC3; tick();
    din_a = 8'h99; tick(); iv[0] = 1'b0;
    while (cyc < n + 1 + 4 * BD + 6) tick();
    chk("t5_queued", cnt_w[0], 2);
    rst_n = 1'b0; model_reset();
    #1 chk("t5_async_reset", {tx_w[0], busy_w[0], ready_w[0], cnt_w[0]}, 6'b101000);
    check_all();
    repeat (3) tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      tick();
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    chk("t5_no_frame", bad, 0);

    rst_n = 1'b0; model_reset(); iv = '1;
    bad = 0;
    repeat (1000) begin
      din_a = 8'($urandom); din_p = 7'($urandom);
      tick();
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) bad++;
    end
    iv = '0; rst_n = 1'b1;
    repeat (200) begin
      tick();
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || cnt_w[0] !== 3'd0) bad++;
    end
    chk("t6_idle", bad, 0);

    for (int k = 0; k < 3000; k++) begin
      for (int d = 0; d < 3; d++) iv[d] = ($urandom_range(0, 99) < 6);
      din_a = 8'($urandom); din_p = 7'($urandom);
      tick();
    end
    iv = '0;
    for (int d = 0; d < 3; d++) wait_idle(d, t1);
    chk("rand_drained", int'(cnt_w[0]) + int'(cnt_w[1]) + int'(cnt_w[2]), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
